// File: rtl/meas_display_pkg.sv
// Shared definitions for the distance display: converter FSM encoding and 7-segment codes.
package meas_display_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble: one add-3/shift step per cycle, 8 cycles per conversion.
module bin2bcd_seq
  import meas_display_pkg::*;
(
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  state_t      state, state_nxt;
  logic [7:0]  sh;
  logic [11:0] acc;
  logic [2:0]  cnt;
  logic [11:0] acc_adj;
  logic [19:0] shifted;
  logic        load;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign acc_adj = {add3(acc[11:8]), add3(acc[7:4]), add3(acc[3:0])};
  assign shifted = {acc_adj, sh} << 1;
  assign busy    = (state == SHIFT);
  assign done    = (state == SHIFT) && (cnt == 3'd7);
  // A start on the final shift cycle chains straight into the next conversion
  assign load    = start && ((state == IDLE) || done);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (done && !start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      if (done)
        bcd <= shifted[19:8];
      if (load) begin
        sh  <= din;
        acc <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        acc <= shifted[19:8];
        sh  <= shifted[7:0];
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/meas_display.sv
// Captures distance results on measReady rising edges, converts to BCD and scans a 3-digit display.
module meas_display
  import meas_display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic [7:0]  meas,
  input  logic        measReady,
  output logic [11:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic             ready_q;
  logic             rise;
  logic             pend_vld;
  logic [7:0]       pend_val;
  logic             conv_start;
  logic [7:0]       conv_din;
  logic             conv_busy;
  logic             conv_done;
  logic [CNT_W-1:0] ref_cnt;
  logic [1:0]       dig_idx;
  logic [3:0]       nib;
  logic             blank;

  assign rise = measReady && !ready_q;

  // A fresh edge always beats an older pending value
  assign conv_start = (rise && (!conv_busy || conv_done)) || (conv_done && pend_vld);
  assign conv_din   = rise ? meas : pend_val;
  assign busy       = conv_busy;

  bin2bcd_seq u_conv (
    .clock  (clock),
    .nReset (nReset),
    .start  (conv_start),
    .din    (conv_din),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (bcd)
  );

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ready_q  <= 1'b0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      valid    <= 1'b0;
    end else begin
      ready_q <= measReady;
      if (conv_done) begin
        pend_vld <= 1'b0;
        valid    <= 1'b1;
      end else if (rise && conv_busy) begin
        pend_vld <= 1'b1;
        pend_val <= meas;
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ref_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (ref_cnt == CNT_MAX) begin
      ref_cnt <= '0;
      dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  assign an = 3'b001 << dig_idx;

  // seg and an both derive from dig_idx, so they cannot drift apart
  always_comb begin
    nib   = bcd[3:0];
    blank = !valid;
    case (dig_idx)
      2'd1: begin
        nib = bcd[7:4];
        if (BLANK_LEADING && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) blank = 1'b1;
      end
      2'd2: begin
        nib = bcd[11:8];
        if (BLANK_LEADING && bcd[11:8] == 4'd0) blank = 1'b1;
      end
      default: nib = bcd[3:0];
    endcase
    seg = blank ? SEG_BLANK : seg_decode(nib);
  end

endmodule
